// File: rtl/led_matrix_pwm.sv
// Multiplexed LED matrix driver: scans one LED per slot, PWMs it from a shadow
// copy of the brightness bus captured once per frame, with blanking at slot start.
module led_matrix_pwm #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int PWM_BITS = 4,
  parameter int STEP     = 2,
  parameter int BLANK    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [ROWS*COLS*PWM_BITS-1:0] level,
  output logic [COLS-1:0]               aled,
  output logic [ROWS-1:0]               kled_tri,
  output logic                          frame_tick
);

  localparam int N        = ROWS * COLS;
  localparam int MAXL     = (1 << PWM_BITS) - 1;
  localparam int SLOT_LEN = BLANK + STEP * MAXL;
  localparam int SW       = (N > 1) ? $clog2(N) : 1;
  localparam int CW       = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;

  logic [SW-1:0]                   s;
  logic [CW-1:0]                   c;
  logic [ROWS*COLS*PWM_BITS-1:0]   shadow;

  logic                last_c;
  logic                last_s;
  logic [PWM_BITS-1:0] lvl;
  logic [COLS-1:0]     aled_n;
  logic [ROWS-1:0]     kled_n;
  logic [31:0]         rel;
  logic [31:0]         lim;
  logic                lit;

  assign last_c = (c == CW'(SLOT_LEN - 1));
  assign last_s = (s == SW'(N - 1));

  // Slot decode: brightness of the scanned LED and its column/group selects.
  always_comb begin
    lvl    = '0;
    aled_n = '1;
    kled_n = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (s == SW'(i)) begin
        lvl    = shadow[i*PWM_BITS +: PWM_BITS];
        aled_n = ~(COLS'(1) << (i % COLS));
        kled_n = ROWS'(1) << (i / COLS);
      end
    end
  end

  // p < level  <=>  (c - BLANK) < STEP*level; during blanking rel wraps to a
  // huge unsigned value, so the single compare also covers the blank phase.
  always_comb begin
    rel = 32'(c) - 32'(BLANK);
    lim = 32'(STEP) * 32'(lvl);
    lit = (rel < lim);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s          <= '0;
      c          <= '0;
      shadow     <= '0;
      aled       <= '1;
      kled_tri   <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= last_c && last_s;
      if (last_c) begin
        c <= '0;
        if (last_s) begin
          s      <= '0;
          shadow <= level;
        end else begin
          s <= s + 1'b1;
        end
      end else begin
        c <= c + 1'b1;
      end
      if (lit && enable) begin
        aled     <= aled_n;
        kled_tri <= kled_n;
      end else begin
        aled     <= '1;
        kled_tri <= '0;
      end
    end
  end

endmodule

// File: tb/tb_led_matrix_pwm.sv
// Bench for led_matrix_pwm: default and small configurations checked every cycle
// against a lit-window model, plus directed frame-level literal expectations.
module tb_led_matrix_pwm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic [63:0] level0 = '0;
  logic [11:0] level1 = '0;
  logic [3:0]  a0, k0;
  logic        t0;
  logic [2:0]  a1;
  logic [1:0]  k1;
  logic        t1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  led_matrix_pwm u0 (
    .clk(clk), .rst(rst), .enable(enable), .level(level0),
    .aled(a0), .kled_tri(k0), .frame_tick(t0)
  );

  led_matrix_pwm #(.ROWS(2), .COLS(3), .PWM_BITS(2), .STEP(1), .BLANK(0)) u1 (
    .clk(clk), .rst(rst), .enable(enable), .level(level1),
    .aled(a1), .kled_tri(k1), .frame_tick(t1)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Each LED owns a slot of slot_len clocks; it is lit for step*level clocks
  // right after the blank window. Result packs {tick, kled[7:0], aled[7:0]}.
  function automatic logic [16:0] model_out(input int cols, input int step, input int blank,
                                            input int slot_len, input int pos, input int sh[64],
                                            input logic en, input logic tk);
    int sl, cy;
    logic [7:0] a, k;
    sl = pos / slot_len;
    cy = pos % slot_len;
    a  = 8'hFF;
    k  = 8'h00;
    if (en && cy >= blank && cy < blank + step * sh[sl]) begin
      a = ~(8'd1 << (sl % cols));
      k = 8'd1 << (sl / cols);
    end
    return {tk, k, a};
  endfunction

  int          cnt0, cnt1;
  int          sh0[64];
  int          sh1[64];
  logic [16:0] exp0, exp1;
  logic        vld0 = 1'b0;
  logic        vld1 = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      cnt0 <= 0;
      for (int i = 0; i < 64; i++) sh0[i] <= 0;
      exp0 <= {1'b0, 8'h00, 8'hFF};
      vld0 <= 1'b1;
    end else begin
      exp0 <= model_out(4, 2, 2, 32, cnt0, sh0, enable, cnt0 == 511);
      if (cnt0 == 511)
        for (int i = 0; i < 16; i++) sh0[i] <= int'(level0[i*4 +: 4]);
      cnt0 <= (cnt0 + 1) % 512;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      cnt1 <= 0;
      for (int i = 0; i < 64; i++) sh1[i] <= 0;
      exp1 <= {1'b0, 8'h00, 8'hFF};
      vld1 <= 1'b1;
    end else begin
      exp1 <= model_out(3, 1, 0, 3, cnt1, sh1, enable, cnt1 == 17);
      if (cnt1 == 17)
        for (int i = 0; i < 6; i++) sh1[i] <= int'(level1[i*2 +: 2]);
      cnt1 <= (cnt1 + 1) % 18;
    end
  end

  always @(negedge clk) begin
    if (vld0) begin
      check("u0_outputs", int'({t0, k0, a0}), int'({exp0[16], exp0[11:8], exp0[3:0]}));
      check("u0_single_led", int'($countones(k0) <= 1 && $countones(~a0) <= 1), 1);
    end
    if (vld1) begin
      check("u1_outputs", int'({t1, k1, a1}), int'({exp1[16], exp1[9:8], exp1[2:0]}));
      check("u1_single_led", int'($countones(k1) <= 1 && $countones(~a1) <= 1), 1);
    end
  end

  // Counts clocks from reset release to the first tick; that frame must be dark.
  task automatic first_frame0();
    int n = 0;
    int lit = 0;
    while (n < 1000) begin
      @(negedge clk);
      n++;
      if (t0) break;
      if (k0 != 0) lit++;
    end
    check("u0_first_tick_cycle", n, 512);
    check("u0_first_frame_dark", lit, 0);
  endtask

  task automatic wait_tick0();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!t0 && n < 1000);
    check("u0_tick_seen", int'(t0), 1);
  endtask

  // Measures one whole frame after the next tick. kind 1: switch level at evk;
  // kind 2: enable low from evk for 100 clocks.
  task automatic measure0(input int evk, input int kind, input logic [3:0] pa, input logic [3:0] pk,
                          output int period, output int lit, output int hits, output int first);
    wait_tick0();
    period = 0; lit = 0; hits = 0; first = -1;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge clk);
      period = k;
      if (k0 != 0) begin
        lit++;
        if (first < 0) first = k;
      end
      if (a0 == pa && k0 == pk) hits++;
      if (kind == 1 && k == evk) level0 = 64'h3333_3333_3333_3333;
      if (kind == 2 && k == evk) enable = 1'b0;
      if (kind == 2 && k == evk + 100) enable = 1'b1;
      if (t0) break;
    end
  endtask

  task automatic measure1();
    int n = 0;
    int lit = 0;
    int hits = 0;
    int per = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (t1) break;
    end
    check("u1_first_tick_cycle", n, 18);
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      per = k;
      if (k1 != 0) lit++;
      if (a1 == 3'b101 && k1 == 2'b10) hits++;
      if (t1) break;
    end
    check("u1_frame_period", per, 18);
    check("u1_lit_per_frame", lit, 12);
    check("u1_led4_cycles", hits, 2);
  endtask

  initial begin
    int per, lit, hits, first, run;
    level0 = 64'h0000_0000_0000_000F;
    level1 = 12'hAAA;
    rst    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_aled", int'(a0), 'hF);
    check("rst_kled", int'(k0), 0);
    check("rst_tick", int'(t0), 0);
    check("rst_aled_small", int'(a1), 'h7);
    rst = 1'b0;

    fork
      first_frame0();
      measure1();
    join

    // LED0 at full brightness: 2 blank clocks then 30 lit clocks
    @(negedge clk); check("led0_blank0", int'(a0), 'hF);
    @(negedge clk); check("led0_blank1", int'(a0), 'hF);
    run = 0;
    repeat (30) begin
      @(negedge clk);
      if (a0 == 4'b1110 && k0 == 4'b0001) run++;
    end
    check("led0_lit_run", run, 30);
    @(negedge clk); check("led0_after_run", int'(k0), 0);

    level0 = 64'h0000_0000_0010_0000;
    measure0(0, 0, 4'b1101, 4'b0010, per, lit, hits, first);
    check("led5_period", per, 512);
    check("led5_lit", lit, 2);
    check("led5_pattern", hits, 2);
    check("led5_first_lit", first, 163);

    level0 = 64'h8888_8888_8888_8888;
    measure0(100, 1, 4'h0, 4'h0, per, lit, hits, first);
    check("all8_lit", lit, 256);
    measure0(0, 0, 4'h0, 4'h0, per, lit, hits, first);
    check("all3_lit", lit, 96);

    level0 = 64'hFFFF_FFFF_FFFF_FFFF;
    measure0(0, 0, 4'h0, 4'h0, per, lit, hits, first);
    check("all15_lit", lit, 480);
    check("all15_period", per, 512);
    measure0(100, 2, 4'h0, 4'h0, per, lit, hits, first);
    check("enable_gap_lit", lit, 386);
    check("enable_gap_period", per, 512);

    // Reset pulse in the middle of slot 7 (lit there with all-15)
    wait_tick0();
    repeat (7 * 32 + 10) @(negedge clk);
    check("pre_rst_lit", int'(k0), 'h8 >> 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_aled", int'(a0), 'hF);
    check("midrst_kled", int'(k0), 0);
    check("midrst_tick", int'(t0), 0);
    first_frame0();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
